fp_to_fixed_converter: RTL and testbench
========================================

Name: fp_to_fixed_converter

Overview:
- Downstream consumer of the floating-point multiplier's result port.
- Accepts one IEEE-754 single-precision value through the multiplier's resultReady/resultAccepted handshake.
- Converts it to signed two's-complement fixed point with FRAC_BITS fractional bits, using a one-bit-per-cycle iterative shifter, and presents it through a valid/taken handshake.
- Saturates and flags out-of-range values.

Parameters:
- OUT_W, 32, fixed-point output width; legal range 25..32.
- FRAC_BITS, 16, fractional bits of the output; legal range 0..OUT_W-1.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- fpIn  input  32  IEEE-754 single value; sampled only on the capture edge.
- resultReady  input  1  upstream has a valid fpIn.
- resultAccepted  output  1  one-cycle pulse acknowledging capture.
- fixOut  output  OUT_W  signed fixed-point result.
- fixValid  output  1  fixOut valid; held until taken.
- fixTaken  input  1  downstream consumes fixOut.
- overflow  output  1  result saturated or input was Inf/NaN; valid with fixValid.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset: state IDLE; resultAccepted, fixValid, overflow, busy = 0; fixOut = 0. Reset mid-operation abandons the conversion; nothing is emitted.
- States: IDLE -> CLASSIFY -> SHIFT -> FINISH -> HOLD -> IDLE.
- IDLE, edge with resultReady=1: latch sign, exp, mant = {1, frac} (24 bits). resultAccepted = 1 for exactly the following cycle. Go to CLASSIFY.
- resultReady is ignored in every state except IDLE.
- CLASSIFY (1 cycle): compute s = exp - 150 + FRAC_BITS (signed).
  - exp = 255, frac = 0 (Inf): saturate, overflow = 1.
  - exp = 255, frac != 0 (NaN): result 0, overflow = 1.
  - exp = 0 (zero or denormal): result 0 (denormals flushed), overflow = 0.
  - s >= OUT_W-23: saturate.
  - s = OUT_W-24: saturate, except negative with frac = 0, which gives exactly -2^(OUT_W-1), overflow = 0.
  - s <= -25: result 0.
  - Otherwise load magnitude register; remaining count = |s|.
  - Special or saturate cases skip SHIFT (0 shift cycles).
- SHIFT: one bit per cycle, left when s > 0, right when s < 0. Right shifts collect guard and sticky bits. Exits when count reaches 0; s = 0 means zero cycles.
- FINISH (1 cycle): optional rounding, then negate if sign = 1.
  - Saturation value: 2^(OUT_W-1)-1 for positive, -2^(OUT_W-1) for negative.
  - Negative zero outputs 0.
- HOLD: fixValid = 1; fixOut and overflow stable. On an edge with fixTaken = 1, go to IDLE; fixValid = 0 the next cycle.
  - fixTaken while fixValid = 0 is ignored.
  - A new capture is possible on the first IDLE edge after leaving HOLD.
- Latency: fixValid rises n+3 edges after the capture edge, where n = shift cycles (max 24).

Optional Feature:
- Macro: FP2FIX_ROUND_NEAREST_EN.
- Defined: FINISH rounds the magnitude half-to-even using guard and sticky bits (symmetric for negatives). Rounding cannot overflow because OUT_W >= 25.
- Undefined: magnitude truncation (round toward zero); guard and sticky logic omitted.

Test Plan:
- Basic value: fpIn = 0x3F800000 (1.0), resultReady held until resultAccepted -> resultAccepted pulses one cycle after capture; fixValid after 10 edges (n = 7); fixOut = 0x00010000; overflow = 0.
- Multiplier product: fpIn = 0xC1220000 (-10.125) -> fixOut = 0xFFF5E000; overflow = 0; n = 4; fixValid held across 5 cycles of fixTaken = 0, then drops one cycle after fixTaken = 1.
- Saturation and boundary:
  - 0x471C4000 (40000.0) -> 0x7FFFFFFF, overflow = 1.
  - 0xC7000000 (-32768.0) -> 0x80000000, overflow = 0.
  - 0xFF800000 (-Inf) -> 0x80000000, overflow = 1.
  - 0x7FC00000 (NaN) -> 0, overflow = 1.
- Zero and underflow: 0x80000000 -> 0; 0x00000001 (denormal) -> 0; 0x33800000 (2^-24) -> 0; overflow = 0 in all three.
- Rounding: fpIn = 0x37C00000 (1.5 LSB) -> fixOut = 1 without the macro, 2 with FP2FIX_ROUND_NEAREST_EN. 0x37A00000 (1.25 LSB) -> 1 in both builds.
- Reset and back-pressure:
  - Assert rst during SHIFT -> next cycle busy = 0, fixValid = 0; a following 1.0 conversion is correct.
  - resultReady = 1 during HOLD -> no second resultAccepted until back in IDLE.

Source files
------------

// File: rtl/fp_to_fixed_converter.sv
// IEEE-754 single to signed fixed-point converter with a one-bit-per-cycle shifter.
// Define FP2FIX_ROUND_NEAREST_EN for half-to-even rounding; the default truncates toward zero.
module fp_to_fixed_converter #(
    parameter int OUT_W     = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             fpIn,
    input  logic                    resultReady,
    output logic                    resultAccepted,
    output logic signed [OUT_W-1:0] fixOut,
    output logic                    fixValid,
    input  logic                    fixTaken,
    output logic                    overflow,
    output logic                    busy
);

    localparam int CNT_W = 11;
    localparam logic signed [10:0] BIAS_S  = 11'sd150;
    localparam logic signed [10:0] FRAC_S  = 11'(FRAC_BITS);
    localparam logic signed [10:0] SAT_S   = 11'(OUT_W - 23);
    localparam logic signed [10:0] EDGE_S  = 11'(OUT_W - 24);
    localparam logic signed [10:0] UNDER_S = -11'sd25;
    localparam logic signed [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLASSIFY,
        S_SHIFT,
        S_FINISH,
        S_HOLD
    } state_t;

    state_t                  state_q, state_d;
    logic                    sign_q, sign_d;
    logic [7:0]              exp_q, exp_d;
    logic [23:0]             mant_q, mant_d;
    logic [OUT_W-1:0]        mag_q, mag_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    left_q, left_d;
    logic                    sat_q, sat_d;
    logic                    zero_q, zero_d;
    logic                    ovf_q, ovf_d;
    logic                    acc_q, acc_d;
    logic signed [OUT_W-1:0] fix_out_q, fix_out_d;
`ifdef FP2FIX_ROUND_NEAREST_EN
    logic                    guard_q, guard_d;
    logic                    sticky_q, sticky_d;
`endif

    logic signed [10:0]      s_val;
    logic signed [10:0]      s_abs;
    logic [OUT_W-1:0]        rnd_mag;

    function automatic logic [OUT_W-1:0] round_mag(
        input logic [OUT_W-1:0] mag,
        input logic             guard,
        input logic             sticky
    );
        // Half-to-even: bump on more than half, or exactly half with an odd LSB.
        round_mag = mag + {{(OUT_W-1){1'b0}}, guard & (sticky | mag[0])};
    endfunction

    always_comb begin
        s_val = $signed({3'b000, exp_q}) - BIAS_S + FRAC_S;
        s_abs = s_val[10] ? -s_val : s_val;
`ifdef FP2FIX_ROUND_NEAREST_EN
        rnd_mag = round_mag(mag_q, guard_q, sticky_q);
`else
        rnd_mag = mag_q;
`endif
    end

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        mant_d    = mant_q;
        mag_d     = mag_q;
        cnt_d     = cnt_q;
        left_d    = left_q;
        sat_d     = sat_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        fix_out_d = fix_out_q;
        acc_d     = 1'b0;
`ifdef FP2FIX_ROUND_NEAREST_EN
        guard_d   = guard_q;
        sticky_d  = sticky_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (resultReady) begin
                    sign_d  = fpIn[31];
                    exp_d   = fpIn[30:23];
                    mant_d  = {1'b1, fpIn[22:0]};
                    acc_d   = 1'b1;
                    state_d = S_CLASSIFY;
                end
            end

            S_CLASSIFY: begin
                sat_d   = 1'b0;
                zero_d  = 1'b0;
                ovf_d   = 1'b0;
                mag_d   = {{(OUT_W-24){1'b0}}, mant_q};
                cnt_d   = s_abs;
                left_d  = ~s_val[10];
                state_d = S_FINISH;
`ifdef FP2FIX_ROUND_NEAREST_EN
                guard_d  = 1'b0;
                sticky_d = 1'b0;
`endif
                if (exp_q == 8'hFF) begin
                    ovf_d = 1'b1;
                    if (mant_q[22:0] == 23'd0) sat_d = 1'b1;
                    else                       zero_d = 1'b1;
                end else if (exp_q == 8'h00) begin
                    zero_d = 1'b1;
                end else if (s_val >= SAT_S) begin
                    sat_d = 1'b1;
                    ovf_d = 1'b1;
                end else if (s_val == EDGE_S) begin
                    // A negative power of two here lands exactly on the most negative code.
                    sat_d = 1'b1;
                    ovf_d = ~(sign_q && (mant_q[22:0] == 23'd0));
                end else if (s_val <= UNDER_S) begin
                    zero_d = 1'b1;
                end else if (s_val != 11'sd0) begin
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (left_q) begin
                    mag_d = mag_q << 1;
                end else begin
                    mag_d = mag_q >> 1;
`ifdef FP2FIX_ROUND_NEAREST_EN
                    guard_d  = mag_q[0];
                    sticky_d = sticky_q | guard_q;
`endif
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 11'd1) state_d = S_FINISH;
            end

            S_FINISH: begin
                if (zero_q)      fix_out_d = '0;
                else if (sat_q)  fix_out_d = sign_q ? MIN_V : MAX_V;
                else if (sign_q) fix_out_d = $signed(-rnd_mag);
                else             fix_out_d = $signed(rnd_mag);
                state_d = S_HOLD;
            end

            S_HOLD: begin
                if (fixTaken) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= 1'b0;
            ovf_q     <= 1'b0;
            fix_out_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            fix_out_q <= fix_out_d;
        end
    end

    // Working datapath registers; every field is rewritten before it is read.
    always_ff @(posedge clk) begin
        sign_q   <= sign_d;
        exp_q    <= exp_d;
        mant_q   <= mant_d;
        mag_q    <= mag_d;
        cnt_q    <= cnt_d;
        left_q   <= left_d;
        sat_q    <= sat_d;
        zero_q   <= zero_d;
`ifdef FP2FIX_ROUND_NEAREST_EN
        guard_q  <= guard_d;
        sticky_q <= sticky_d;
`endif
    end

    assign resultAccepted = acc_q;
    assign fixOut         = fix_out_q;
    assign overflow       = ovf_q;
    assign fixValid       = (state_q == S_HOLD);
    assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_fp_to_fixed_converter.sv
// Randomized self-checking bench for fp_to_fixed_converter against an arithmetic reference model.
module tb_fp_to_fixed_converter;

    localparam int OUT_W     = 32;
    localparam int FRAC_BITS = 16;

    logic                    clk;
    logic                    rst;
    logic [31:0]             fpIn;
    logic                    resultReady;
    logic                    resultAccepted;
    logic signed [OUT_W-1:0] fixOut;
    logic                    fixValid;
    logic                    fixTaken;
    logic                    overflow;
    logic                    busy;

    int n_cmp;
    int n_bad;

    fp_to_fixed_converter #(.OUT_W(OUT_W), .FRAC_BITS(FRAC_BITS)) dut (
        .clk            (clk),
        .rst            (rst),
        .fpIn           (fpIn),
        .resultReady    (resultReady),
        .resultAccepted (resultAccepted),
        .fixOut         (fixOut),
        .fixValid       (fixValid),
        .fixTaken       (fixTaken),
        .overflow       (overflow),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exact value mant * 2^s, rounded or truncated, then range-limited against the signed output range.
    function automatic void model(input logic [31:0] f, output logic [OUT_W-1:0] v,
                                  output logic ov, output int n);
        int     e;
        int     s;
        bit     neg;
        longint m, q, rem, half, lim;
        e   = int'(f[30:23]);
        neg = f[31];
        m   = longint'({1'b1, f[22:0]});
        s   = e - 150 + FRAC_BITS;
        v   = '0;
        ov  = 1'b0;
        n   = 0;
        if (e == 255) begin
            ov = 1'b1;
            if (f[22:0] == 23'd0) v = neg ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
            return;
        end
        if (e == 0) return;
        if (s >= -24 && s <= OUT_W - 25) n = (s < 0) ? -s : s;
        if (s >= 40) begin
            ov = 1'b1;
            v  = neg ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
            return;
        end
        if (s < -40) return;
        if (s >= 0) begin
            q = m << s;
        end else begin
            q   = m >> (-s);
            rem = m - (q << (-s));
`ifdef FP2FIX_ROUND_NEAREST_EN
            half = longint'(1) << (-s - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
`else
            half = 0;
            if (rem < half) q = 0;
`endif
        end
        lim = neg ? (longint'(1) << (OUT_W - 1)) : ((longint'(1) << (OUT_W - 1)) - 1);
        if (q > lim) begin
            ov = 1'b1;
            v  = neg ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            v = neg ? OUT_W'(-q) : OUT_W'(q);
        end
    endfunction

    // Drives one conversion and hands back what was observed; callers do the checking.
    task automatic run_conv(input logic [31:0] f, input int hold_cycles,
                            output logic [OUT_W-1:0] out, output logic ov,
                            output int acc_cyc, output int acc_cnt, output int lat,
                            output logic held_ok, output logic dropped, output logic tmo);
        acc_cyc = -1;
        acc_cnt = 0;
        lat     = -1;
        tmo     = 1'b0;
        held_ok = 1'b1;
        dropped = 1'b0;
        out     = '0;
        ov      = 1'b0;
        @(negedge clk);
        fpIn        = f;
        resultReady = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (resultAccepted) begin
                acc_cnt++;
                if (acc_cyc < 0) acc_cyc = k;
                resultReady = 1'b0;
            end
            if (fixValid) begin
                lat = k;
                break;
            end
        end
        resultReady = 1'b0;
        if (lat < 0) begin
            tmo = 1'b1;
            return;
        end
        out = fixOut;
        ov  = overflow;
        for (int k = 0; k < hold_cycles; k++) begin
            @(negedge clk);
            if (!fixValid || fixOut !== out || overflow !== ov) held_ok = 1'b0;
        end
        fixTaken = 1'b1;
        @(negedge clk);
        fixTaken = 1'b0;
        dropped  = ~fixValid;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (fixValid !== 1'b0) begin n_bad++; $display("FAIL reset_fixValid got %b want 0", fixValid); end
        n_cmp++; if (resultAccepted !== 1'b0) begin n_bad++; $display("FAIL reset_accepted got %b want 0", resultAccepted); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %b want 0", overflow); end
        n_cmp++; if (fixOut !== '0) begin n_bad++; $display("FAIL reset_fixOut got %h want 0", fixOut); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [OUT_W-1:0] out; logic ov, held, drop, tmo; int ac, acn, lat;
        run_conv(32'h3F800000, 0, out, ov, ac, acn, lat, held, drop, tmo);
        n_cmp++; if (tmo) begin n_bad++; $display("FAIL basic_timeout no fixValid within bound"); end
        n_cmp++; if (ac !== 1) begin n_bad++; $display("FAIL basic_accept_cycle got %0d want 1", ac); end
        n_cmp++; if (acn !== 1) begin n_bad++; $display("FAIL basic_accept_pulses got %0d want 1", acn); end
        n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL basic_latency got %0d want 10", lat); end
        n_cmp++; if (out !== 32'h00010000) begin n_bad++; $display("FAIL basic_value got %h want 00010000", out); end
        n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL basic_overflow got %b want 0", ov); end
    endtask

    task automatic test_product;
        logic [OUT_W-1:0] out; logic ov, held, drop, tmo; int ac, acn, lat;
        run_conv(32'hC1220000, 5, out, ov, ac, acn, lat, held, drop, tmo);
        n_cmp++; if (tmo) begin n_bad++; $display("FAIL product_timeout no fixValid within bound"); end
        n_cmp++; if (out !== 32'hFFF5E000) begin n_bad++; $display("FAIL product_value got %h want FFF5E000", out); end
        n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL product_overflow got %b want 0", ov); end
        n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL product_latency got %0d want 7", lat); end
        n_cmp++; if (held !== 1'b1) begin n_bad++; $display("FAIL product_hold got unstable want stable"); end
        n_cmp++; if (drop !== 1'b1) begin n_bad++; $display("FAIL product_release got fixValid=1 want 0"); end
    endtask

    task automatic test_saturation;
        logic [31:0] vin [8];
        logic [31:0] vexp[8];
        logic        oexp[8];
        logic [OUT_W-1:0] out; logic ov, held, drop, tmo; int ac, acn, lat;
        vin[0] = 32'h471C4000; vexp[0] = 32'h7FFFFFFF; oexp[0] = 1'b1;
        vin[1] = 32'hC7000000; vexp[1] = 32'h80000000; oexp[1] = 1'b0;
        vin[2] = 32'hFF800000; vexp[2] = 32'h80000000; oexp[2] = 1'b1;
        vin[3] = 32'h7FC00000; vexp[3] = 32'h00000000; oexp[3] = 1'b1;
        vin[4] = 32'h80000000; vexp[4] = 32'h00000000; oexp[4] = 1'b0;
        vin[5] = 32'h00000001; vexp[5] = 32'h00000000; oexp[5] = 1'b0;
        vin[6] = 32'h33800000; vexp[6] = 32'h00000000; oexp[6] = 1'b0;
        vin[7] = 32'hC7000001; vexp[7] = 32'h80000000; oexp[7] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run_conv(vin[i], 1, out, ov, ac, acn, lat, held, drop, tmo);
            n_cmp++;
            if (tmo || out !== vexp[i] || ov !== oexp[i]) begin
                n_bad++;
                $display("FAIL boundary_%h got %h/ovf=%b want %h/ovf=%b", vin[i], out, ov, vexp[i], oexp[i]);
            end
            n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL boundary_latency_%h got %0d want 3", vin[i], lat); end
        end
    endtask

    task automatic test_rounding;
        logic [OUT_W-1:0] out; logic ov, held, drop, tmo; int ac, acn, lat;
        logic [OUT_W-1:0] want15;
`ifdef FP2FIX_ROUND_NEAREST_EN
        want15 = 2;
`else
        want15 = 1;
`endif
        run_conv(32'h37C00000, 0, out, ov, ac, acn, lat, held, drop, tmo);
        n_cmp++; if (tmo || out !== want15) begin n_bad++; $display("FAIL round_1p5 got %h want %h", out, want15); end
        run_conv(32'h37A00000, 0, out, ov, ac, acn, lat, held, drop, tmo);
        n_cmp++; if (tmo || out !== 1) begin n_bad++; $display("FAIL round_1p25 got %h want 1", out); end
        run_conv(32'hB7C00000, 0, out, ov, ac, acn, lat, held, drop, tmo);
        n_cmp++; if (tmo || out !== OUT_W'(-int'(want15))) begin n_bad++; $display("FAIL round_neg1p5 got %h want %h", out, OUT_W'(-int'(want15))); end
    endtask

    task automatic test_random;
        logic [OUT_W-1:0] out, vref; logic ov, oref, held, drop, tmo; int ac, acn, lat, nref;
        logic [31:0] f;
        logic [7:0]  e;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 15))
                0:       e = 8'h00;
                1:       e = 8'hFF;
                default: e = 8'($urandom_range(100, 160));
            endcase
            f = {1'($urandom_range(0, 1)), e, 23'($urandom)};
            if ($urandom_range(0, 7) == 0) f[22:0] = '0;
            model(f, vref, oref, nref);
            run_conv(f, int'($urandom_range(0, 2)), out, ov, ac, acn, lat, held, drop, tmo);
            n_cmp++;
            if (tmo || out !== vref || ov !== oref) begin
                n_bad++;
                $display("FAIL random_%h got %h/ovf=%b want %h/ovf=%b", f, out, ov, vref, oref);
            end
            n_cmp++;
            if (lat !== nref + 3 || drop !== 1'b1) begin
                n_bad++;
                $display("FAIL random_timing_%h got lat=%0d rel=%b want lat=%0d rel=1", f, lat, drop, nref + 3);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [OUT_W-1:0] out; logic ov, held, drop, tmo; int ac, acn, lat;
        logic seen;
        @(negedge clk);
        fpIn        = 32'h3B800000;
        resultReady = 1'b1;
        @(negedge clk);
        resultReady = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midreset_busy_before got %b want 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy got %b want 0", busy); end
        n_cmp++; if (fixValid !== 1'b0) begin n_bad++; $display("FAIL midreset_fixValid got %b want 0", fixValid); end
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (fixValid) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midreset_emitted got fixValid=1 want none"); end
        run_conv(32'h3F800000, 0, out, ov, ac, acn, lat, held, drop, tmo);
        n_cmp++; if (tmo || out !== 32'h00010000 || ov !== 1'b0) begin n_bad++; $display("FAIL midreset_after got %h/ovf=%b want 00010000/ovf=0", out, ov); end
    endtask

    task automatic test_back_to_back;
        int  lat;
        logic extra;
        lat = -1;
        @(negedge clk);
        fpIn        = 32'h3F800000;
        resultReady = 1'b1;
        @(negedge clk);
        fpIn = 32'h40000000;
        for (int k = 0; k < 60; k++) begin
            if (fixValid) begin lat = k; break; end
            @(negedge clk);
        end
        n_cmp++; if (lat < 0) begin n_bad++; $display("FAIL b2b_timeout no fixValid within bound"); end
        extra = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resultAccepted) extra = 1'b1;
        end
        n_cmp++; if (extra !== 1'b0) begin n_bad++; $display("FAIL b2b_accept_in_hold got 1 want 0"); end
        fixTaken = 1'b1;
        @(negedge clk);
        fixTaken = 1'b0;
        n_cmp++; if (resultAccepted !== 1'b0 || fixValid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got acc=%b vld=%b want 0/0", resultAccepted, fixValid); end
        @(negedge clk);
        n_cmp++; if (resultAccepted !== 1'b1) begin n_bad++; $display("FAIL b2b_recapture got %b want 1", resultAccepted); end
        resultReady = 1'b0;
        lat = -1;
        for (int k = 0; k < 60; k++) begin
            if (fixValid) begin lat = k; break; end
            @(negedge clk);
        end
        n_cmp++; if (lat < 0 || fixOut !== 32'h00020000) begin n_bad++; $display("FAIL b2b_second got %h want 00020000", fixOut); end
        fixTaken = 1'b1;
        @(negedge clk);
        fixTaken = 1'b0;
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst         = 1'b1;
        fpIn        = '0;
        resultReady = 1'b0;
        fixTaken    = 1'b0;
        test_reset();
        test_basic();
        test_product();
        test_saturation();
        test_rounding();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
